sync_fifo: RTL and testbench



---
 rtl/axi4bus_pkg.sv | 37 +++
 rtl/fifo_ram.sv | 26 ++
 rtl/sync_fifo.sv | 156 +++++++++++++++
 tb/tb_sync_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4bus_pkg.sv
// Shared constants, helper functions and parameter-range checks for the AXI4
// buffering blocks.
`ifndef AXI4BUS_PKG_SV
`define AXI4BUS_PKG_SV

// Elaboration-time rejection of a parameter outside [lo..hi].
`define AXI4BUS_CHECK_RANGE(tag, val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin : tag \
    $error("axi4bus: parameter out of range"); \
  end

package axi4bus_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Entries held: memory plus the optional output register.
  function automatic int fifo_cap(input int depth, input int out_reg);
    return (1 << depth) + out_reg;
  endfunction

  function automatic int fifo_count_w(input int depth);
    return depth + 2;
  endfunction

endpackage

`endif

// File: rtl/fifo_ram.sv
// Simple dual-port RAM for FIFO storage: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             WEN,
  input  logic [DEPTH-1:0] WADDR,
  input  logic [WIDTH-1:0] DIN,
  input  logic [DEPTH-1:0] RADDR,
  output logic [WIDTH-1:0] DOUT
);

  localparam int ENTRIES = 1 << DEPTH;

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge CLK) begin
    if (WEN) begin
      mem_q[WADDR] <= DIN;
    end
  end

  assign DOUT = mem_q[RADDR];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock valid/ready FIFO with occupancy count, almost flags, flush and
// an optional registered output stage.
module sync_fifo
  import axi4bus_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int OUT_REG  = 0,
  parameter int AF_LEVEL = (1 << DEPTH) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             WVALID,
  output logic             WREADY,
  output logic [WIDTH-1:0] RDATA,
  output logic             RVALID,
  input  logic             RREADY,
  output logic [DEPTH+1:0] COUNT,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY
);

  localparam int CAP = fifo_cap(DEPTH, OUT_REG);
  localparam int CW  = fifo_count_w(DEPTH);
  localparam int PW  = DEPTH + 1;
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);

  `AXI4BUS_CHECK_RANGE(g_chk_depth, DEPTH, 1, 28)
  `AXI4BUS_CHECK_RANGE(g_chk_oreg, OUT_REG, 0, 1)
  `AXI4BUS_CHECK_RANGE(g_chk_af, AF_LEVEL, 1, CAP)
  `AXI4BUS_CHECK_RANGE(g_chk_ae, AE_LEVEL, 0, CAP - 1)

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_rdata_s;
  logic             mem_empty_s;
  logic             mem_full_s;
  logic             push_s;
  logic             pop_s;
  logic             rd_adv_s;

  // Full when the wrap bits differ but the addresses match.
  assign mem_empty_s = (wptr_q == rptr_q);
  assign mem_full_s  = (wptr_q[DEPTH] != rptr_q[DEPTH]) &&
                       (wptr_q[DEPTH-1:0] == rptr_q[DEPTH-1:0]);

  assign WREADY = ~mem_full_s & ~FLUSH;
  assign push_s = WVALID & WREADY;
  assign pop_s  = RVALID & RREADY;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .CLK   (CLK),
    .WEN   (push_s),
    .WADDR (wptr_q[DEPTH-1:0]),
    .DIN   (WDATA),
    .RADDR (rptr_q[DEPTH-1:0]),
    .DOUT  (mem_rdata_s)
  );

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] oreg_q, oreg_d;
      logic             oval_q, oval_d;
      logic             load_s;

      // Refill the register whenever it is empty or being drained this cycle.
      assign load_s = ~mem_empty_s & (~oval_q | pop_s) & ~FLUSH;

      always_comb begin
        oreg_d = oreg_q;
        oval_d = oval_q;
        if (FLUSH) begin
          oval_d = 1'b0;
        end else if (load_s) begin
          oreg_d = mem_rdata_s;
          oval_d = 1'b1;
        end else if (pop_s) begin
          oval_d = 1'b0;
        end else begin
          oval_d = oval_q;
        end
      end

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          oreg_q <= '0;
          oval_q <= 1'b0;
        end else begin
          oreg_q <= oreg_d;
          oval_q <= oval_d;
        end
      end

      assign RVALID   = oval_q & ~FLUSH;
      assign RDATA    = oreg_q;
      assign rd_adv_s = load_s;
    end else begin : g_fwft
      assign RVALID   = ~mem_empty_s & ~FLUSH;
      assign RDATA    = mem_rdata_s;
      assign rd_adv_s = pop_s;
    end
  endgenerate

  // Loads into the output register move data but never change COUNT.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (FLUSH) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_adv_s) begin
        rptr_d = rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign COUNT        = count_q;
  assign ALMOST_FULL  = (count_q >= AF_C);
  assign ALMOST_EMPTY = (count_q <= AE_C);

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: one FWFT instance and one registered-output
// instance, both DEPTH=2, driven from per-scenario tasks.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        flush0 = 1'b0, w0_valid = 1'b0, r0_ready = 1'b0;
  logic [31:0] w0_data = 32'h0;
  logic        wready0, rvalid0, af0, ae0;
  logic [31:0] rdata0;
  logic [3:0]  count0;

  logic        flush1 = 1'b0, w1_valid = 1'b0, r1_ready = 1'b0;
  logic [31:0] w1_data = 32'h0;
  logic        wready1, rvalid1, af1, ae1;
  logic [31:0] rdata1;
  logic [3:0]  count1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          m0_cnt = 0;
  int          m1_mem = 0;
  logic        m1_oval = 1'b0;

  sync_fifo #(.WIDTH(32), .DEPTH(2), .OUT_REG(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut0 (
    .CLK(clk), .RESET(rst), .FLUSH(flush0), .WDATA(w0_data), .WVALID(w0_valid),
    .WREADY(wready0), .RDATA(rdata0), .RVALID(rvalid0), .RREADY(r0_ready),
    .COUNT(count0), .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(2), .OUT_REG(1), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .FLUSH(flush1), .WDATA(w1_data), .WVALID(w1_valid),
    .WREADY(wready1), .RDATA(rdata1), .RVALID(rvalid1), .RREADY(r1_ready),
    .COUNT(count1), .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // One clock of FWFT traffic: predict handshakes, score pops, check COUNT/flags.
  task automatic step0(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
    logic        ew, ev;
    logic [31:0] exp_d;
    int          ec;
    w0_valid = wv; w0_data = wd; r0_ready = rr; flush0 = fl;
    ew = (m0_cnt < 4) && !fl;
    ev = (m0_cnt != 0) && !fl;
    @(negedge clk);
    checks++;
    if (wready0 !== ew) begin failures++; $display("FAIL d0_wready got=%0b exp=%0b", wready0, ew); end
    checks++;
    if (rvalid0 !== ev) begin failures++; $display("FAIL d0_rvalid got=%0b exp=%0b", rvalid0, ev); end
    if (ev && rr) begin
      checks++;
      if (q0.size() == 0) begin
        failures++; $display("FAIL d0_scoreboard got=pop exp=empty_queue");
      end else begin
        exp_d = q0.pop_front();
        if (rdata0 !== exp_d) begin failures++; $display("FAIL d0_rdata got=%h exp=%h", rdata0, exp_d); end
      end
    end
    if (wv && ew) q0.push_back(wd);
    if (fl) begin
      m0_cnt = 0; q0.delete();
    end else begin
      m0_cnt = m0_cnt + ((wv && ew) ? 1 : 0) - ((ev && rr) ? 1 : 0);
    end
    @(posedge clk); #1;
    w0_valid = 1'b0; r0_ready = 1'b0; flush0 = 1'b0;
    ec = m0_cnt;
    checks++;
    if (count0 !== 4'(ec)) begin failures++; $display("FAIL d0_count got=%0d exp=%0d", count0, ec); end
    checks++;
    if (af0 !== (ec >= 3)) begin failures++; $display("FAIL d0_almost_full got=%0b exp=%0b", af0, (ec >= 3)); end
    checks++;
    if (ae0 !== (ec <= 1)) begin failures++; $display("FAIL d0_almost_empty got=%0b exp=%0b", ae0, (ec <= 1)); end
  endtask

  // One clock of registered-output traffic, modelling memory occupancy and the register.
  task automatic step1(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
    logic        ew, ev, pu, po, ld;
    logic [31:0] exp_d;
    int          ec;
    w1_valid = wv; w1_data = wd; r1_ready = rr; flush1 = fl;
    ew = (m1_mem < 4) && !fl;
    ev = m1_oval && !fl;
    @(negedge clk);
    checks++;
    if (wready1 !== ew) begin failures++; $display("FAIL d1_wready got=%0b exp=%0b", wready1, ew); end
    checks++;
    if (rvalid1 !== ev) begin failures++; $display("FAIL d1_rvalid got=%0b exp=%0b", rvalid1, ev); end
    pu = wv && ew;
    po = ev && rr;
    if (po) begin
      checks++;
      if (q1.size() == 0) begin
        failures++; $display("FAIL d1_scoreboard got=pop exp=empty_queue");
      end else begin
        exp_d = q1.pop_front();
        if (rdata1 !== exp_d) begin failures++; $display("FAIL d1_rdata got=%h exp=%h", rdata1, exp_d); end
      end
    end
    if (pu) q1.push_back(wd);
    ld = (m1_mem > 0) && (!m1_oval || po) && !fl;
    if (fl) begin
      m1_mem = 0; m1_oval = 1'b0; q1.delete();
    end else begin
      m1_mem  = m1_mem + (pu ? 1 : 0) - (ld ? 1 : 0);
      m1_oval = ld ? 1'b1 : (po ? 1'b0 : m1_oval);
    end
    @(posedge clk); #1;
    w1_valid = 1'b0; r1_ready = 1'b0; flush1 = 1'b0;
    ec = m1_mem + (m1_oval ? 1 : 0);
    checks++;
    if (count1 !== 4'(ec)) begin failures++; $display("FAIL d1_count got=%0d exp=%0d", count1, ec); end
    checks++;
    if (af1 !== (ec >= 4)) begin failures++; $display("FAIL d1_almost_full got=%0b exp=%0b", af1, (ec >= 4)); end
    checks++;
    if (ae1 !== (ec <= 1)) begin failures++; $display("FAIL d1_almost_empty got=%0b exp=%0b", ae1, (ec <= 1)); end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0b%0b exp=00", rvalid0, rvalid1); end
    checks++;
    if (wready0 !== 1'b1 || wready1 !== 1'b1) begin failures++; $display("FAIL reset_wready got=%0b%0b exp=11", wready0, wready1); end
    checks++;
    if (count0 !== 4'd0 || count1 !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d,%0d exp=0,0", count0, count1); end
    checks++;
    if (ae0 !== 1'b1 || af0 !== 1'b0 || ae1 !== 1'b1 || af1 !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=ae%0b af%0b ae%0b af%0b exp=ae1 af0 ae1 af0", ae0, af0, ae1, af1);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) step0(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    checks++;
    if (wready0 !== 1'b0) begin failures++; $display("FAIL fill_wready_low got=%0b exp=0", wready0); end
    step0(1'b1, 32'hFF, 1'b0, 1'b0);
    checks++;
    if (count0 !== 4'd4) begin failures++; $display("FAIL fill_fifth_refused got=%0d exp=4", count0); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) step0(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (rvalid0 !== 1'b0 || ae0 !== 1'b1 || count0 !== 4'd0) begin
      failures++; $display("FAIL drain_empty got=rv%0b ae%0b cnt%0d exp=rv0 ae1 cnt0", rvalid0, ae0, count0);
    end
  endtask

  task automatic test_wrap();
    step0(1'b1, 32'hC0, 1'b0, 1'b0);
    step0(1'b1, 32'hC1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step0(1'b1, 32'hC2 + 32'(i), 1'b1, 1'b0);
      checks++;
      if (count0 !== 4'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", count0); end
    end
    step0(1'b0, 32'h0, 1'b1, 1'b0);
    step0(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) step0(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
    step0(1'b1, 32'hBF, 1'b1, 1'b0);
    checks++;
    if (wready0 !== 1'b1 || count0 !== 4'd3) begin
      failures++; $display("FAIL full_pop got=wr%0b cnt%0d exp=wr1 cnt3", wready0, count0);
    end
    for (int i = 0; i < 3; i++) step0(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_outreg();
    step1(1'b1, 32'h55, 1'b0, 1'b0);
    checks++;
    if (rvalid1 !== 1'b0) begin failures++; $display("FAIL oreg_early_valid got=%0b exp=0", rvalid1); end
    step1(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h55) begin
      failures++; $display("FAIL oreg_latency got=rv%0b d%h exp=rv1 d00000055", rvalid1, rdata1);
    end
    for (int i = 0; i < 4; i++) step1(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0);
    checks++;
    if (count1 !== 4'd5 || wready1 !== 1'b0) begin
      failures++; $display("FAIL oreg_capacity got=cnt%0d wr%0b exp=cnt5 wr0", count1, wready1);
    end
    step1(1'b1, 32'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step1(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (rvalid1 !== 1'b0 || count1 !== 4'd0) begin
      failures++; $display("FAIL oreg_drain got=rv%0b cnt%0d exp=rv0 cnt0", rvalid1, count1);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step0(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
    step0(1'b1, 32'hDD, 1'b0, 1'b1);
    checks++;
    if (count0 !== 4'd0 || rvalid0 !== 1'b0) begin
      failures++; $display("FAIL flush_clear got=cnt%0d rv%0b exp=cnt0 rv0", count0, rvalid0);
    end
    step0(1'b1, 32'hE0, 1'b0, 1'b0);
    step0(1'b0, 32'h0, 1'b1, 1'b0);
    step1(1'b1, 32'h70, 1'b0, 1'b0);
    step1(1'b1, 32'h71, 1'b0, 1'b0);
    step1(1'b1, 32'h72, 1'b0, 1'b1);
    step1(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    step0(1'b1, 32'hF0, 1'b0, 1'b0);
    step0(1'b1, 32'hF1, 1'b0, 1'b0);
    step1(1'b1, 32'hF8, 1'b0, 1'b0);
    step1(1'b1, 32'hF9, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rvalid0 !== 1'b0 || count0 !== 4'd0) begin
      failures++; $display("FAIL async_reset_d0 got=rv%0b cnt%0d exp=rv0 cnt0", rvalid0, count0);
    end
    checks++;
    if (rvalid1 !== 1'b0 || count1 !== 4'd0) begin
      failures++; $display("FAIL async_reset_d1 got=rv%0b cnt%0d exp=rv0 cnt0", rvalid1, count1);
    end
    q0.delete(); q1.delete();
    m0_cnt = 0; m1_mem = 0; m1_oval = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step1(1'b0, 32'h0, 1'b1, 1'b0);
    step0(1'b1, 32'h99, 1'b0, 1'b0);
    step0(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_pop();
    test_outreg();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
